// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding and default width for serial_add_ctrl
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder cell used as the serial datapath
module full_adder (
    input  logic a,
    input  logic b,
    input  logic Cin,
    output logic Cout,
    output logic Sum
);

    assign Sum  = a ^ b ^ Cin;
    assign Cout = (a & b) | (Cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial a+b+cin over WIDTH cycles with start/done handshake
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   r_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum;
    logic               fa_cout;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .Cin  (carry),
        .Cout (fa_cout),
        .Sum  (fa_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= {fa_sum, r_sr[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    // Final bit: publish the result straight from the adder, bypassing r_sr.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum   <= {fa_sum, r_sr[WIDTH-1:1]};
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at WIDTH 8 and 4
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 addition; optionally re-pulses start with other operands mid-RUN.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                        input int restart_at, input string tag);
        int n;
        int busy_cnt;
        int both_hi;
        logic [8:0] want;
        logic [7:0] prev_sum;
        logic       prev_cout;
        want = 9'(ta) + 9'(tb2) + 9'(tc);
        @(negedge clk);
        prev_sum  = sum8;
        prev_cout = cout8;
        a8 = ta; b8 = tb2; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~ta; b8 = ~tb2; cin8 = ~tc;
        n = 0; busy_cnt = 0; both_hi = 0;
        while (!done8 && n < 20) begin
            if (busy8) busy_cnt++;
            if (sum8 !== prev_sum || cout8 !== prev_cout) both_hi++;
            if (n == restart_at) begin
                a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'd8);
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, ".held_during_run"}, 32'(both_hi), 32'd0);
        check({tag, ".busy_at_done"}, 32'(busy8), 32'd0);
        check({tag, ".result"}, {23'd0, cout8, sum8}, {23'd0, want});
        @(negedge clk);
        check({tag, ".single_done"}, 32'(done8), 32'd0);
        check({tag, ".idle_after"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        int n;
        int seen_done;
        int last_done;
        logic [4:0] want4;
        logic [7:0] ra, rb;
        logic       rc;

        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy8), 32'd0);
        check("reset.done", 32'(done8), 32'd0);
        check("reset.sum",  32'(sum8),  32'd0);
        check("reset.cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;

        run8(8'h00, 8'h00, 1'b0, -1, "zero");
        run8(8'hFF, 8'h01, 1'b0, -1, "ripple_ff01");
        run8(8'hA5, 8'h5A, 1'b1, -1, "ripple_a55a");
        run8(8'h7F, 8'h01, 1'b0, -1, "nooverflow");
        run8(8'h33, 8'h44, 1'b0, 3,  "restart_ignored");
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run8(ra, rb, rc, -1, "random");
        end

        // Reset during RUN aborts the addition and clears the outputs.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h66; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.busy", 32'(busy8), 32'd0);
        check("midreset.sum",  32'(sum8),  32'd0);
        check("midreset.cout", 32'(cout8), 32'd0);
        check("midreset.done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen_done++;
        end
        check("midreset.no_done", 32'(seen_done), 32'd0);
        run8(8'h03, 8'h04, 1'b0, -1, "after_reset");

        // Exhaustive WIDTH=4 with start held high: operands advance on each done.
        @(negedge clk);
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
        last_done = -1;
        for (int k = 0; k < 512; k++) begin
            want4 = 5'(a4) + 5'(b4) + 5'(cin4);
            n = 0;
            @(negedge clk);
            while (!done4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("w4.result", {27'd0, cout4, sum4}, {27'd0, want4});
            if (k > 0) check("w4.throughput", 32'(n + 1), 32'd6);
            last_done = k;
            {cin4, b4, a4} = 9'(k + 1);
        end
        start4 = 1'b0;
        check("w4.all_done", 32'(last_done), 32'd511);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
